// File: rtl/console_uart.sv
// Console UART: CPU bytes go through a TX FIFO and out as 8N1 on TXD. 8N1 on RXD lands in a one-byte holding register.
// TXD falls 2 edges after a write into an empty FIFO. CRDY drops only while the FIFO is full. RX drops a byte and flags it when the holding reg is occupied.
module console_uart #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int TX_FIFO_DEPTH_POW = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] COUT,
  input  logic       CWR,
  output logic       CRDY,
  output logic [7:0] CIN,
  output logic       CRDA,
  input  logic       CACK,
  input  logic       RXD,
  output logic       TXD,
  output logic       RX_OVERRUN,
  output logic       FRAME_ERR
);

  localparam int DEPTH = 2 ** TX_FIFO_DEPTH_POW;
  localparam int PW    = TX_FIFO_DEPTH_POW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [7:0]  fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] fifo_count, fifo_count_nxt;
  logic        push, pop, fifo_empty;

  uart_state_t tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic        tx_bit_end;

  uart_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_s1, rx_s2, rx_bit_end;

  assign fifo_empty = (fifo_count == '0);
  assign push       = CWR && CRDY;
  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign rx_bit_end = (rx_cnt == BIT_LAST);
  // The next byte is taken either from idle or at the final stop-bit edge, so frames run back to back.
  assign pop = !fifo_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_bit_end));

  always_comb begin
    fifo_count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_nxt = fifo_count + (PW + 1)'(1);
      2'b01:   fifo_count_nxt = fifo_count - (PW + 1)'(1);
      default: fifo_count_nxt = fifo_count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= COUT;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      CRDY       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count_nxt;
      CRDY       <= (fifo_count_nxt != FULL_COUNT);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      TXD      <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          TXD    <= 1'b1;
          tx_cnt <= '0;
          if (pop) begin
            tx_sh    <= fifo_mem[rd_ptr];
            tx_state <= START;
          end
        end
        START: begin
          TXD <= 1'b0;
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        DATA: begin
          TXD <= tx_sh[0];
          if (tx_bit_end) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == 3'd7) tx_state <= STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        STOP: begin
          TXD <= 1'b1;
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (pop) begin
              tx_sh    <= fifo_mem[rd_ptr];
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      CIN        <= '0;
      CRDA       <= 1'b0;
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      rx_s1      <= RXD;
      rx_s2      <= rx_s1;
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= 1'b0;
      // An acknowledge clears CRDA unless a delivery below sets it again on the same edge.
      if (CACK) CRDA <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= START;
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        DATA: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        STOP: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
            if (!rx_s2) begin
              FRAME_ERR <= 1'b1;
            end else if (!CRDA || CACK) begin
              CIN  <= rx_sh;
              CRDA <= 1'b1;
            end else begin
              RX_OVERRUN <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_uart.sv
// Directed bench for console_uart with CLKS_PER_BIT=8 and a 4-entry TX FIFO.
module tb_console_uart;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] COUT;
  logic       CWR;
  logic       CRDY;
  logic [7:0] CIN;
  logic       CRDA;
  logic       CACK;
  logic       RXD;
  logic       TXD;
  logic       RX_OVERRUN;
  logic       FRAME_ERR;

  int vectors;
  int miscompares;

  console_uart #(.CLKS_PER_BIT(8), .TX_FIFO_DEPTH_POW(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .COUT(COUT), .CWR(CWR), .CRDY(CRDY),
    .CIN(CIN), .CRDA(CRDA), .CACK(CACK), .RXD(RXD), .TXD(TXD),
    .RX_OVERRUN(RX_OVERRUN), .FRAME_ERR(FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit 0 is the start bit, bits 1..8 are data LSB first, bit 9 is the stop bit.
  function automatic logic [9:0] frame_bits(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Drives one RX frame plus 10 idle cycles and records what the DUT did. Index c means "just after edge c".
  task automatic rx_frame(input logic [7:0] d, input logic stop, input bit ack_at_stop,
                          output int crda_rise, output int ovr_n, output int ovr_at,
                          output int ferr_n, output int ferr_at);
    logic [9:0] f;
    logic crda_prev;
    f = frame_bits(d, stop);
    crda_rise = -1; ovr_n = 0; ovr_at = -1; ferr_n = 0; ferr_at = -1;
    crda_prev = CRDA;
    for (int c = 0; c < 90; c++) begin
      RXD  = (c < 80) ? f[c / 8] : 1'b1;
      CACK = ack_at_stop && (c == 78);
      @(negedge CLK);
      if (CRDA && !crda_prev && crda_rise < 0) crda_rise = c;
      crda_prev = CRDA;
      if (RX_OVERRUN) begin ovr_n++; ovr_at = c; end
      if (FRAME_ERR)  begin ferr_n++; ferr_at = c; end
    end
    CACK = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (TXD !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", TXD); end
    vectors++; if (CRDY !== 1'b0) begin miscompares++; $display("FAIL reset_crdy: got %b want 0", CRDY); end
    vectors++; if (CRDA !== 1'b0) begin miscompares++; $display("FAIL reset_crda: got %b want 0", CRDA); end
    vectors++; if (CIN !== 8'h00) begin miscompares++; $display("FAIL reset_cin: got %h want 00", CIN); end
    vectors++; if (RX_OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", RX_OVERRUN); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
    RESET_N = 1'b1;
    @(negedge CLK);
    vectors++; if (CRDY !== 1'b1) begin miscompares++; $display("FAIL reset_release_crdy: got %b want 1", CRDY); end
  endtask

  task automatic test_single_tx();
    logic [9:0] f;
    logic exp;
    int idx;
    f = frame_bits(8'h41, 1'b1);
    for (int cyc = 0; cyc < 102; cyc++) begin
      CWR  = (cyc == 0);
      COUT = 8'h41;
      @(negedge CLK);
      idx = cyc - 2;
      exp = (cyc < 2 || idx >= 80) ? 1'b1 : f[idx / 8];
      vectors++;
      if (TXD !== exp) begin miscompares++; $display("FAIL single_tx_txd cyc=%0d: got %b want %b", cyc, TXD, exp); end
      vectors++;
      if (CRDY !== 1'b1) begin miscompares++; $display("FAIL single_tx_crdy cyc=%0d: got %b want 1", cyc, CRDY); end
    end
    CWR = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [9:0] f;
    logic exp_txd, exp_crdy;
    int idx;
    // The 1st byte is popped at once. Writes at 6,12,18,24 fill the 4 entries and the write at 30 is dropped.
    for (int cyc = 0; cyc < 422; cyc++) begin
      CWR  = (cyc % 6 == 0) && (cyc <= 30);
      COUT = 8'((cyc / 6) + 1);
      @(negedge CLK);
      idx = cyc - 2;
      if (cyc < 2 || idx >= 400) begin
        exp_txd = 1'b1;
      end else begin
        f = frame_bits(8'((idx / 80) + 1), 1'b1);
        exp_txd = f[(idx % 80) / 8];
      end
      exp_crdy = !(cyc >= 24 && cyc < 81);
      vectors++;
      if (TXD !== exp_txd) begin miscompares++; $display("FAIL fifo_txd cyc=%0d: got %b want %b", cyc, TXD, exp_txd); end
      vectors++;
      if (CRDY !== exp_crdy) begin miscompares++; $display("FAIL fifo_crdy cyc=%0d: got %b want %b", cyc, CRDY, exp_crdy); end
    end
    CWR = 1'b0;
  endtask

  task automatic test_rx_ack();
    int rise, on, oa, fn, fa;
    rx_frame(8'h5A, 1'b1, 1'b0, rise, on, oa, fn, fa);
    vectors++; if (rise !== 78) begin miscompares++; $display("FAIL rx_crda_rise: got %0d want 78", rise); end
    vectors++; if (CIN !== 8'h5A) begin miscompares++; $display("FAIL rx_cin: got %h want 5a", CIN); end
    vectors++; if (on !== 0 || fn !== 0) begin miscompares++; $display("FAIL rx_flags: got ovr=%0d ferr=%0d want 0 0", on, fn); end
    CACK = 1'b1;
    @(negedge CLK);
    CACK = 1'b0;
    vectors++; if (CRDA !== 1'b0) begin miscompares++; $display("FAIL ack_crda: got %b want 0", CRDA); end
    vectors++; if (CIN !== 8'h5A) begin miscompares++; $display("FAIL ack_cin: got %h want 5a", CIN); end
  endtask

  task automatic test_overrun();
    int rise, on, oa, fn, fa;
    rx_frame(8'h11, 1'b1, 1'b0, rise, on, oa, fn, fa);
    vectors++; if (CIN !== 8'h11 || CRDA !== 1'b1) begin miscompares++; $display("FAIL ovr_first: got cin=%h crda=%b want 11 1", CIN, CRDA); end
    rx_frame(8'h22, 1'b1, 1'b0, rise, on, oa, fn, fa);
    vectors++; if (on !== 1 || oa !== 78) begin miscompares++; $display("FAIL ovr_pulse: got n=%0d at=%0d want 1 at 78", on, oa); end
    vectors++; if (CIN !== 8'h11 || CRDA !== 1'b1) begin miscompares++; $display("FAIL ovr_kept: got cin=%h crda=%b want 11 1", CIN, CRDA); end
    rx_frame(8'h22, 1'b1, 1'b1, rise, on, oa, fn, fa);
    vectors++; if (on !== 0) begin miscompares++; $display("FAIL ovr_ack_nopulse: got %0d want 0", on); end
    vectors++; if (CIN !== 8'h22 || CRDA !== 1'b1) begin miscompares++; $display("FAIL ovr_ack_replace: got cin=%h crda=%b want 22 1", CIN, CRDA); end
    CACK = 1'b1;
    @(negedge CLK);
    CACK = 1'b0;
    vectors++; if (CRDA !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b want 0", CRDA); end
  endtask

  task automatic test_errors();
    int rise, on, oa, fn, fa, flags, crda_seen;
    flags = 0; crda_seen = 0;
    for (int c = 0; c < 30; c++) begin
      RXD = (c < 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (RX_OVERRUN || FRAME_ERR) flags++;
      if (CRDA) crda_seen++;
    end
    vectors++; if (flags !== 0 || crda_seen !== 0) begin miscompares++; $display("FAIL glitch: got flags=%0d crda=%0d want 0 0", flags, crda_seen); end
    rx_frame(8'h33, 1'b0, 1'b0, rise, on, oa, fn, fa);
    vectors++; if (fn !== 1 || fa !== 78) begin miscompares++; $display("FAIL ferr_pulse: got n=%0d at=%0d want 1 at 78", fn, fa); end
    vectors++; if (on !== 0 || rise !== -1 || CRDA !== 1'b0) begin miscompares++; $display("FAIL ferr_nodeliver: got ovr=%0d rise=%0d crda=%b", on, rise, CRDA); end
    vectors++; if (CIN !== 8'h22) begin miscompares++; $display("FAIL ferr_cin: got %h want 22", CIN); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    logic exp;
    f = frame_bits(8'hA5, 1'b1);
    for (int cyc = 0; cyc < 36; cyc++) begin
      CWR  = (cyc == 0) || (cyc == 6);
      COUT = (cyc == 0) ? 8'hA5 : 8'h5A;
      @(negedge CLK);
      exp = (cyc < 2) ? 1'b1 : f[(cyc - 2) / 8];
      vectors++;
      if (TXD !== exp) begin miscompares++; $display("FAIL mid_pre_txd cyc=%0d: got %b want %b", cyc, TXD, exp); end
    end
    CWR = 1'b0;
    RESET_N = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      vectors++; if (TXD !== 1'b1) begin miscompares++; $display("FAIL mid_rst_txd c=%0d: got %b want 1", c, TXD); end
      vectors++; if (CRDY !== 1'b0) begin miscompares++; $display("FAIL mid_rst_crdy c=%0d: got %b want 0", c, CRDY); end
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    vectors++; if (CRDY !== 1'b1) begin miscompares++; $display("FAIL mid_release_crdy: got %b want 1", CRDY); end
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      vectors++;
      if (TXD !== 1'b1) begin miscompares++; $display("FAIL mid_post_txd c=%0d: got %b want 1", c, TXD); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET_N = 1'b0;
    CWR = 1'b0;
    COUT = 8'h00;
    CACK = 1'b0;
    RXD = 1'b1;
    test_reset();
    test_single_tx();
    test_fifo_full();
    test_rx_ack();
    test_overrun();
    test_errors();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
